// File: rtl/vec_reg_arbiter.sv
// rtl/vec_reg_arbiter.sv - round-robin arbiter with bus lock sharing one VecReg
// Element values travel as raw IEEE-754 single-precision bit patterns.
package vec_reg_pkg;
    typedef enum logic [1:0] {
        RD_DISABLE = 2'd0,
        RD_VEC     = 2'd1,
        RD_SCALAR  = 2'd2
    } VecDataReadOp_t;

    typedef enum logic [1:0] {
        WR_DISABLE = 2'd0,
        WR_VEC     = 2'd1,
        WR_SCALAR  = 2'd2
    } VecDataWriteOp_t;
endpackage

module vec_reg_arbiter
    import vec_reg_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
    parameter int NUM_REQ         = 4,
    parameter int LOCK_TIMEOUT    = 16
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ-1:0]                       req_write,
    input  logic [NUM_REQ-1:0]                       req_scalar,
    input  logic [NUM_REQ-1:0]                       req_lock,
    input  logic [NUM_REQ-1:0][WIDTH_ADDR_SIZE-1:0]  req_param,
    input  logic [NUM_REQ-1:0][WIDTH-1:0][31:0]      req_data,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic [WIDTH-1:0][31:0]                   rsp_data,
    output VecDataReadOp_t                           vr_read_op,
    output logic [WIDTH_ADDR_SIZE-1:0]               vr_read_param,
    output VecDataWriteOp_t                          vr_write_op,
    output logic [WIDTH_ADDR_SIZE-1:0]               vr_write_param,
    output logic [WIDTH-1:0][31:0]                   vr_data_in,
    input  logic [WIDTH-1:0][31:0]                   vr_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                  state_q, state_d;
    idx_t                    rr_ptr_q, rr_ptr_d;
    idx_t                    owner_q, owner_d;
    logic [CNT_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0][31:0]  rsp_data_q, rsp_data_d;

    logic                    grant_valid;
    idx_t                    grant_idx;
    idx_t                    scan;

    function automatic idx_t wrap_inc(input idx_t i);
        return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
    endfunction

    // While locked only the owner is eligible; otherwise scan upward from rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_q;
        scan        = rr_ptr_q;
        if (state_q == S_LOCKED) begin
            grant_valid = req_valid[owner_q];
            grant_idx   = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_valid && req_valid[scan]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan;
                end
                scan = wrap_inc(scan);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        vr_read_op     = RD_DISABLE;
        vr_read_param  = '0;
        vr_write_op    = WR_DISABLE;
        vr_write_param = '0;
        vr_data_in     = '0;
        if (grant_valid) begin
            if (req_write[grant_idx]) begin
                vr_write_op    = req_scalar[grant_idx] ? WR_SCALAR : WR_VEC;
                vr_write_param = req_param[grant_idx];
                vr_data_in     = req_data[grant_idx];
            end else begin
                vr_read_op     = req_scalar[grant_idx] ? RD_SCALAR : RD_VEC;
                vr_read_param  = req_param[grant_idx];
            end
        end
    end

    // Scalar reads return only element 0; the rest of the vector reads as 0.0.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (grant_valid && !req_write[grant_idx]) begin
            rsp_valid_d[grant_idx] = 1'b1;
            if (req_scalar[grant_idx]) begin
                rsp_data_d    = '0;
                rsp_data_d[0] = vr_data_out[0];
            end else begin
                rsp_data_d = vr_data_out;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    rr_ptr_d = wrap_inc(grant_idx);
                    if (req_lock[grant_idx]) begin
                        state_d    = S_LOCKED;
                        owner_d    = grant_idx;
                        idle_cnt_d = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (grant_valid) begin
                    idle_cnt_d = '0;
                    if (!req_lock[owner_q]) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = wrap_inc(owner_q);
                    end
                end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    // Owner stalled too long: force the lock open.
                    state_d    = S_IDLE;
                    rr_ptr_d   = wrap_inc(owner_q);
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            idle_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/vec_reg_arbiter.md
# vec_reg_arbiter

Round-robin arbiter that shares one vector register (`VecReg`) between `NUM_REQ` requesters, such as the vector ALU, the load/store unit and the host debug port. Each cycle it grants at most one request. The granted request drives the register's read/write op, param and data lines. Read results are registered and returned one cycle later to the requester that issued them. An optional bus lock lets one requester run an uninterrupted sequence of operations, and a lock timeout guards against a stalled lock owner.

## Interface
- `WIDTH`, 128, vector length in elements (matches `VecReg`).
- `WIDTH_ADDR_SIZE`, `$clog2(WIDTH)`, width of element index params.
- `NUM_REQ`, 4, number of requesters (≥2).
- `LOCK_TIMEOUT`, 16, consecutive idle owner cycles before a lock is forcibly released (≥1).
- `clock`  in  1  single clock, posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `[NUM_REQ-1:0]`  request present.
- `req_ready`  out  `[NUM_REQ-1:0]`  grant; transfer when valid&ready.
- `req_write`  in  `[NUM_REQ-1:0]`  1 = write, 0 = read.
- `req_scalar`  in  `[NUM_REQ-1:0]`  1 = scalar op (SCALAR enum), 0 = whole-vector op (VEC enum).
- `req_lock`  in  `[NUM_REQ-1:0]`  hold the bus after this transfer.
- `req_param`  in  `[NUM_REQ-1:0][WIDTH_ADDR_SIZE-1:0]`  element index for scalar ops.
- `req_data`  in  `shortreal [NUM_REQ-1:0][WIDTH-1:0]`  write data (element 0 only for scalar).
- `rsp_valid`  out  `[NUM_REQ-1:0]`  one-cycle pulse; read data ready for that requester.
- `rsp_data`  out  `shortreal [WIDTH-1:0]`  registered read data, shared by all requesters.
- `vr_read_op`  out  `VecDataReadOp_t`  to `VecReg`.
- `vr_read_param`  out  `WIDTH_ADDR_SIZE`  to `VecReg`.
- `vr_write_op`  out  `VecDataWriteOp_t`  to `VecReg`.
- `vr_write_param`  out  `WIDTH_ADDR_SIZE`  to `VecReg`.
- `vr_data_in`  out  `shortreal [WIDTH-1:0]`  to `VecReg`.
- `vr_data_out`  in  `shortreal [WIDTH-1:0]`  from `VecReg` (combinational read).

## Operation
**State machine.** Two states, `IDLE` and `LOCKED`. Registers: `rr_ptr` (index), `owner` (index) and `idle_cnt` (counts to `LOCK_TIMEOUT`).

**IDLE.**
- Grant the first `i` with `req_valid[i]` = 1, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- On a transfer by `i`, set `rr_ptr` ← (`i`+1) mod `NUM_REQ`.
- If `req_lock[i]` = 1 on that transfer, go to `LOCKED`, set `owner` ← `i` and `idle_cnt` ← 0.

**LOCKED.**
- Only `owner` is eligible; all other `req_ready` bits are 0.
- Owner transfers with `req_lock` = 1: stay in `LOCKED`, `idle_cnt` ← 0.
- Owner transfers with `req_lock` = 0: go to `IDLE`, `rr_ptr` ← `owner`+1.
- Owner `req_valid` = 0: `idle_cnt` increments. When `idle_cnt` reaches `LOCK_TIMEOUT`−1 in an idle cycle, go to `IDLE` on the next edge and set `rr_ptr` ← `owner`+1.

**Grant properties.**
- `req_ready` is one-hot or zero.
- `req_ready[i]` may depend combinationally on `req_valid`.
- `req_ready[i]` is never 1 while `req_valid[i]` = 0.

**Drive of `VecReg` for the granted request.**
- Read: `vr_read_op` = VEC or SCALAR, `vr_read_param` = `req_param`; write op = DISABLE.
- Write: `vr_write_op` = VEC or SCALAR, `vr_write_param` = `req_param`, `vr_data_in` = `req_data[g]`; read op = DISABLE.
- No grant: both ops DISABLE, params 0, `vr_data_in` all 0.0.

**Read return.**
- On a read transfer, `rsp_data` ← `vr_data_out` at the edge.
- At the same edge, `rsp_valid[g]` ← 1 for exactly one cycle.
- For scalar reads, `rsp_data[0]` holds the element and all other elements are 0.0.
- `rsp_data` holds its value until the next read transfer.
- There is no response backpressure: requesters must accept the response.

**Reset.**
- `reset_n` low asynchronously sets: state `IDLE`, `rr_ptr` 0, `owner` 0, `idle_cnt` 0, `rsp_valid` 0, `rsp_data` all 0.0.
- Combinational outputs follow the rules above. With every `req_valid` low they are: ops DISABLE, params 0, `vr_data_in` all 0.0, `req_ready` 0.
- A reset asserted mid-lock releases the lock. An in-flight read response is dropped.

## Timing
- Request to grant: 0 cycles (same-cycle combinational grant).
- Write effect: a write transferred in cycle N lands in `VecReg` at the edge ending cycle N.
- Read: a read transferred in cycle N has `rsp_valid` and `rsp_data` valid in cycle N+1.
- Write in N followed by a read of the same element in N+1 returns the new value.
- Throughput: one operation per cycle, sustained by one requester (lock or sole requester) or by alternating requesters.
- Lock release on a final transfer: requesters other than `owner` become eligible in cycle N+1.
- Lock release by timeout: the lock ends at the edge after `LOCK_TIMEOUT` consecutive idle owner cycles.

## Test plan
- **Reset:** reset asserted → all outputs at the listed reset values. Then requester 0 does a scalar write, param 5, data 3.5, followed by a scalar read, param 5 → `rsp_valid[0]` pulses one cycle after the read with `rsp_data[0]` = 3.5 and all other elements 0.0.
- **Round-robin:** all 4 requesters hold valid reads for 8 cycles → grants in order 0, 1, 2, 3, 0, 1, 2, 3; each `rsp_valid` pulse goes to the previous cycle's grantee.
- **Lock:** requester 2 does 3 vector writes with lock = 1, 1, 0 while requesters 0, 1 and 3 stay valid → requester 2 granted 3 consecutive cycles; requester 3 granted next.
- **Lock timeout:** with `LOCK_TIMEOUT` = 16, requester 1 locks, then drops valid while requester 0 is valid → requester 0 has no grant for 16 cycles and is granted in the 17th.
- **Read-after-write:** vector write of ramp 0.0..127.0 in cycle N, vector read in N+1 → `rsp_data` equals the ramp in N+2.
- **Reset mid-lock:** requester 3 locks, `reset_n` is pulsed low, requester 0 is then valid → requester 0 is granted in the first cycle after reset deasserts, and there is no stray `rsp_valid`.
